// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S frame constants and receiver state encoding
package i2s_pkg;

    localparam int I2S_SLOT_BITS    = 32;
    localparam int I2S_SAMPLE_WIDTH = 24;
    localparam int I2S_FRAME_BITS   = 2 * I2S_SLOT_BITS;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

endpackage

// File: rtl/i2s_sclk_edge.sv
// rtl/i2s_sclk_edge.sv - registers the codec pins and strobes each sclk rise
module i2s_sclk_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sclk_i,
    input  logic lrclk_i,
    input  logic sdata_i,
    output logic rise_o,
    output logic lrclk_s_o,
    output logic sdata_s_o
);

    logic sclk_q;
    logic sclk_qq;
    logic lrclk_q;
    logic sdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_q  <= 1'b0;
            sclk_qq <= 1'b0;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
        end else begin
            sclk_q  <= sclk_i;
            sclk_qq <= sclk_q;
            lrclk_q <= lrclk_i;
            sdata_q <= sdata_i;
        end
    end

    assign rise_o    = sclk_q & ~sclk_qq;
    assign lrclk_s_o = lrclk_q;
    assign sdata_s_o = sdata_q;

endmodule

// File: rtl/i2s_line_in_rx.sv
// rtl/i2s_line_in_rx.sv - I2S line-in deserialiser delivering checked stereo pairs
module i2s_line_in_rx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
    parameter int SLOT_BITS    = I2S_SLOT_BITS
) (
    input  logic                    line_in_mclk,
    input  logic                    rst,
    input  logic                    line_in_sclk,
    input  logic                    line_in_lrclk,
    input  logic                    line_in_sdata,
    output logic [SAMPLE_WIDTH-1:0] sample_l,
    output logic [SAMPLE_WIDTH-1:0] sample_r,
    output logic                    sample_valid,
    output logic                    frame_err
);

    localparam int CNT_W = $clog2(SLOT_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_WIDTH);

    logic rise;
    logic lrclk_s;
    logic sdata_s;
    logic boundary;

    i2s_state_e             state_q,     state_d;
    logic                   lrclk_prev_q, lrclk_prev_d;
    logic [CNT_W-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [SAMPLE_WIDTH-1:0] shift_q,    shift_d;
    logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
    logic [SAMPLE_WIDTH-1:0] sample_l_q, sample_l_d;
    logic [SAMPLE_WIDTH-1:0] sample_r_q, sample_r_d;
    logic                   valid_q,     valid_d;
    logic                   err_q,       err_d;

    i2s_sclk_edge u_edge (
        .clk_i     (line_in_mclk),
        .rst_i     (rst),
        .sclk_i    (line_in_sclk),
        .lrclk_i   (line_in_lrclk),
        .sdata_i   (line_in_sdata),
        .rise_o    (rise),
        .lrclk_s_o (lrclk_s),
        .sdata_s_o (sdata_s)
    );

    always_ff @(posedge line_in_mclk) begin
        if (rst) begin
            state_q      <= SYNC;
            lrclk_prev_q <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            left_hold_q  <= '0;
            sample_l_q   <= '0;
            sample_r_q   <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lrclk_prev_q <= lrclk_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            left_hold_q  <= left_hold_d;
            sample_l_q   <= sample_l_d;
            sample_r_q   <= sample_r_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lrclk_prev_d = lrclk_prev_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        left_hold_d  = left_hold_q;
        sample_l_d   = sample_l_q;
        sample_r_d   = sample_r_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        boundary     = rise && (lrclk_s != lrclk_prev_q);

        if (rise) begin
            lrclk_prev_d = lrclk_s;
            if (boundary) begin
                // The boundary rise is the I2S delay bit: it resets the count and is never captured.
                bit_cnt_d = '0;
                case (state_q)
                    SYNC: begin
                        if (!lrclk_s) state_d = LEFT;
                    end
                    LEFT: begin
                        if (lrclk_s) begin
                            if (bit_cnt_q == CNT_MAX) begin
                                left_hold_d = shift_q;
                                state_d     = RIGHT;
                            end else begin
                                err_d   = 1'b1;
                                state_d = SYNC;
                            end
                        end
                    end
                    RIGHT: begin
                        if (!lrclk_s) begin
                            if (bit_cnt_q == CNT_MAX) begin
                                sample_l_d = left_hold_q;
                                sample_r_d = shift_q;
                                valid_d    = 1'b1;
                                state_d    = LEFT;
                            end else begin
                                err_d   = 1'b1;
                                state_d = SYNC;
                            end
                        end
                    end
                    default: state_d = SYNC;
                endcase
            end else begin
                if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
                // bit_cnt_q < SAMPLE_WIDTH means this rise is slot bit 1..SAMPLE_WIDTH.
                if (bit_cnt_q < CNT_SAMPLE) shift_d = {shift_q[SAMPLE_WIDTH-2:0], sdata_s};
            end
        end
    end

    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_i2s_line_in_rx.sv
// tb/tb_i2s_line_in_rx.sv - directed scoreboard bench for the I2S line-in receiver
`timescale 1ns/1ps
module tb_i2s_line_in_rx;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        lrclk = 1'b0;
    logic        sdata = 1'b0;
    logic [23:0] sample_l;
    logic [23:0] sample_r;
    logic        sample_valid;
    logic        frame_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [8:0]  div_cnt = '0;
    logic        short_req = 1'b0;
    logic        rst_seen = 1'b0;
    logic        frame_clean = 1'b0;
    logic [23:0] cur_l = '0;
    logic [23:0] cur_r = '0;
    logic [47:0] tx_q[$];
    logic [23:0] exp_l[$];
    logic [23:0] exp_r[$];

    i2s_line_in_rx dut (
        .line_in_mclk  (mclk),
        .rst           (rst),
        .line_in_sclk  (sclk),
        .line_in_lrclk (lrclk),
        .line_in_sdata (sdata),
        .sample_l      (sample_l),
        .sample_r      (sample_r),
        .sample_valid  (sample_valid),
        .frame_err     (frame_err)
    );

    always #22.14 mclk = ~mclk;

    always @(posedge mclk) begin
        cyc = cyc + 1;
        if (rst) rst_seen = 1'b1;
    end

    // Codec model: mclk/8 bit clock, mclk/512 word clock, MSB at slot bit 1.
    initial begin
        int b;
        logic [23:0] w;
        forever begin
            @(negedge mclk);
            if (short_req && div_cnt == 9'd159) begin
                div_cnt     = 9'd256;
                short_req   = 1'b0;
                frame_clean = 1'b0;
            end else begin
                div_cnt = div_cnt + 9'd1;
            end
            if (div_cnt == 9'd0) begin
                if (frame_clean) begin
                    exp_l.push_back(cur_l);
                    exp_r.push_back(cur_r);
                end
                if (tx_q.size() > 0) {cur_l, cur_r} = tx_q.pop_front();
                else {cur_l, cur_r} = {24'($urandom), 24'($urandom)};
                frame_clean = 1'b1;
            end
            if (rst_seen) begin
                frame_clean = 1'b0;
                rst_seen    = 1'b0;
            end
            sclk  = div_cnt[2];
            lrclk = div_cnt[8];
            b     = int'(div_cnt[7:3]);
            w     = div_cnt[8] ? cur_r : cur_l;
            sdata = (b >= 1 && b <= 24) ? w[24-b] : 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic wait_event(output logic v, output logic e, output int t);
        v = 1'b0;
        e = 1'b0;
        t = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge mclk);
            if (sample_valid || frame_err) begin
                v = sample_valid;
                e = frame_err;
                t = cyc;
                return;
            end
        end
        check("event_timeout", 32'(v | e), 32'd1);
    endtask

    task automatic expect_pair(input string tag, output logic [23:0] l, output logic [23:0] r);
        logic v, e;
        int   t;
        l = '0;
        r = '0;
        wait_event(v, e, t);
        check({tag, "_valid"}, 32'(v), 32'd1);
        check({tag, "_no_err"}, 32'(e), 32'd0);
        check({tag, "_exp_avail"}, 32'(exp_l.size() != 0), 32'd1);
        if (exp_l.size() != 0) begin
            l = exp_l.pop_front();
            r = exp_r.pop_front();
            check({tag, "_l"}, 32'(sample_l), 32'(l));
            check({tag, "_r"}, 32'(sample_r), 32'(r));
        end
    endtask

    initial begin
        logic [23:0] last_l, last_r;
        logic        v, e;
        int          t1, t2, t3;

        tx_q.push_back({24'h123456, 24'hABCDEF});
        tx_q.push_back({24'h7FFFFF, 24'h800000});
        tx_q.push_back({24'h000001, 24'hFFFFFF});

        repeat (4) @(negedge mclk);
        check("rst_sample_l", 32'(sample_l), 32'd0);
        check("rst_sample_r", 32'(sample_r), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);

        // Release reset in the right slot so the startup partial frame must be discarded.
        for (int i = 0; i < 1000 && div_cnt != 9'd300; i++) @(negedge mclk);
        rst = 1'b0;

        expect_pair("basic", last_l, last_r);
        t1 = cyc;
        check("basic_l_const", 32'(last_l), 32'h123456);
        @(negedge mclk);
        check("valid_width", 32'(sample_valid), 32'd0);

        expect_pair("ext1", last_l, last_r);
        t2 = cyc;
        check("spacing1", 32'(t2 - t1), 32'd512);
        expect_pair("ext2", last_l, last_r);
        t3 = cyc;
        check("spacing2", 32'(t3 - t2), 32'd512);
        check("ext2_r_const", 32'(last_r), 32'hFFFFFF);

        expect_pair("pre_short", last_l, last_r);
        short_req = 1'b1;
        wait_event(v, e, t1);
        check("short_err", 32'(e), 32'd1);
        check("short_no_valid", 32'(v), 32'd0);
        check("short_hold_l", 32'(sample_l), 32'(last_l));
        check("short_hold_r", 32'(sample_r), 32'(last_r));
        @(negedge mclk);
        check("err_width", 32'(frame_err), 32'd0);
        expect_pair("post_short", last_l, last_r);

        expect_pair("pre_rst", last_l, last_r);
        // Slot bit 10 of the right slot.
        for (int i = 0; i < 1000 && div_cnt != 9'd340; i++) @(negedge mclk);
        rst = 1'b1;
        @(negedge mclk);
        rst = 1'b0;
        check("mid_rst_l", 32'(sample_l), 32'd0);
        check("mid_rst_r", 32'(sample_r), 32'd0);
        check("mid_rst_valid", 32'(sample_valid), 32'd0);
        check("mid_rst_err", 32'(frame_err), 32'd0);
        exp_l.delete();
        exp_r.delete();
        expect_pair("post_rst", last_l, last_r);
        expect_pair("steady", last_l, last_r);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
